// File: rtl/ofs_plat_axi_mem_wr_arb2.sv
// Two-source AXI write arbiter onto a single memory sink.
// A source is granted only when its AW and first W beat are both present,
// and both go to the sink in the same cycle. The grant is then held for
// the rest of the burst. The source index is prepended to the sink-side ID,
// and write responses are routed back using that top ID bit.
// All payload paths are combinational, so the arbiter adds no latency.
module ofs_plat_axi_mem_wr_arb2 #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      s0_awvalid,
    output logic                      s0_awready,
    input  logic [ID_WIDTH-1:0]       s0_awid,
    input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
    input  logic [7:0]                s0_awlen,
    input  logic                      s0_wvalid,
    output logic                      s0_wready,
    input  logic [DATA_WIDTH-1:0]     s0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
    input  logic                      s0_wlast,
    output logic                      s0_bvalid,
    input  logic                      s0_bready,
    output logic [ID_WIDTH-1:0]       s0_bid,
    output logic [1:0]                s0_bresp,

    input  logic                      s1_awvalid,
    output logic                      s1_awready,
    input  logic [ID_WIDTH-1:0]       s1_awid,
    input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
    input  logic [7:0]                s1_awlen,
    input  logic                      s1_wvalid,
    output logic                      s1_wready,
    input  logic [DATA_WIDTH-1:0]     s1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
    input  logic                      s1_wlast,
    output logic                      s1_bvalid,
    input  logic                      s1_bready,
    output logic [ID_WIDTH-1:0]       s1_bid,
    output logic [1:0]                s1_bresp,

    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ID_WIDTH:0]         m_awid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [ID_WIDTH:0]         m_bid,
    input  logic [1:0]                m_bresp,

    output logic                      proto_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t        state_reg;
    logic          owner_reg;
    logic          rr_last_reg;
    logic [7:0]    beats_left_reg;
    logic          proto_err_reg;

    // Per-source views so muxing can be indexed by source number.
    logic [1:0]              awvalid_v;
    logic [1:0]              wvalid_v;
    logic [1:0]              wlast_v;
    logic [1:0]              bready_v;
    logic [1:0]              awready_v;
    logic [1:0]              wready_v;
    logic [1:0]              bvalid_v;
    logic [ID_WIDTH-1:0]     awid_v   [2];
    logic [ADDR_WIDTH-1:0]   awaddr_v [2];
    logic [7:0]              awlen_v  [2];
    logic [DATA_WIDTH-1:0]   wdata_v  [2];
    logic [STRB_WIDTH-1:0]   wstrb_v  [2];

    assign awvalid_v   = {s1_awvalid, s0_awvalid};
    assign wvalid_v    = {s1_wvalid,  s0_wvalid};
    assign wlast_v     = {s1_wlast,   s0_wlast};
    assign bready_v    = {s1_bready,  s0_bready};
    assign awid_v[0]   = s0_awid;
    assign awid_v[1]   = s1_awid;
    assign awaddr_v[0] = s0_awaddr;
    assign awaddr_v[1] = s1_awaddr;
    assign awlen_v[0]  = s0_awlen;
    assign awlen_v[1]  = s1_awlen;
    assign wdata_v[0]  = s0_wdata;
    assign wdata_v[1]  = s1_wdata;
    assign wstrb_v[0]  = s0_wstrb;
    assign wstrb_v[1]  = s1_wstrb;

    // Grant and handshake terms.
    logic [1:0] elig;
    logic       any_elig;
    logic       winner;
    logic       is_idle;
    logic       sel;
    logic       sop_fire;
    logic       burst_fire;
    logic       sel_wlast;
    logic       beat_err;

    assign elig     = awvalid_v & wvalid_v;
    assign any_elig = |elig;
    // On a tie, the source that did not win last time is granted.
    assign winner   = (elig == 2'b11) ? ~rr_last_reg : elig[1];
    assign is_idle  = (state_reg == ST_IDLE);
    assign sel      = is_idle ? winner : owner_reg;
    assign sel_wlast = wlast_v[sel];

    assign sop_fire   = !reset && is_idle && any_elig && m_awready && m_wready;
    assign burst_fire = !reset && !is_idle && wvalid_v[owner_reg] && m_wready;

    // beats_left holds the beats still owed after the SOP beat. A beat is the
    // last one exactly when nothing is owed after it.
    always_comb begin
        beat_err = 1'b0;
        if (sop_fire) begin
            beat_err = sel_wlast ? (awlen_v[winner] != 8'd0) : (awlen_v[winner] == 8'd0);
        end else if (burst_fire) begin
            beat_err = sel_wlast ? (beats_left_reg != 8'd1) : (beats_left_reg <= 8'd1);
        end
    end

    // Sink-side request channels.
    assign m_awvalid = !reset && is_idle && any_elig;
    assign m_wvalid  = !reset && (is_idle ? any_elig : wvalid_v[owner_reg]);
    assign m_awid    = {winner, awid_v[winner]};
    assign m_awaddr  = awaddr_v[winner];
    assign m_awlen   = awlen_v[winner];
    assign m_wdata   = wdata_v[sel];
    assign m_wstrb   = wstrb_v[sel];
    assign m_wlast   = sel_wlast;

    // Responses are steered by the source bit carried in the top of the ID.
    assign m_bready  = !reset && bready_v[m_bid[ID_WIDTH]];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            localparam logic SRC = 1'(gi);
            assign awready_v[gi] = !reset && is_idle && any_elig && (winner == SRC)
                                   && m_awready && m_wready;
            assign wready_v[gi]  = is_idle ? awready_v[gi]
                                           : (!reset && (owner_reg == SRC) && m_wready);
            assign bvalid_v[gi]  = !reset && m_bvalid && (m_bid[ID_WIDTH] == SRC);
        end
    endgenerate

    assign s0_awready = awready_v[0];
    assign s1_awready = awready_v[1];
    assign s0_wready  = wready_v[0];
    assign s1_wready  = wready_v[1];
    assign s0_bvalid  = bvalid_v[0];
    assign s1_bvalid  = bvalid_v[1];
    assign s0_bid     = m_bid[ID_WIDTH-1:0];
    assign s1_bid     = m_bid[ID_WIDTH-1:0];
    assign s0_bresp   = m_bresp;
    assign s1_bresp   = m_bresp;
    assign proto_err  = proto_err_reg;

    // Grant/burst state machine and the sticky beat-count error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            rr_last_reg    <= 1'b1;
            beats_left_reg <= 8'd0;
            proto_err_reg  <= 1'b0;
        end else begin
            if (beat_err) begin
                proto_err_reg <= 1'b1;
            end
            if (sop_fire) begin
                rr_last_reg    <= winner;
                owner_reg      <= winner;
                beats_left_reg <= awlen_v[winner];
                if (!sel_wlast) begin
                    state_reg <= ST_BURST;
                end
            end else if (burst_fire) begin
                if (beats_left_reg != 8'd0) begin
                    beats_left_reg <= beats_left_reg - 8'd1;
                end
                if (sel_wlast) begin
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofs_plat_axi_mem_wr_arb2.sv
// Bench for the two-source AXI write arbiter. Source drivers push the sink
// transactions they expect into scoreboard queues in the hand-computed
// arbitration order; a monitor pops and compares on every sink handshake.
module tb_ofs_plat_axi_mem_wr_arb2;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int IW  = 8;
    localparam int TMO = 60;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [1:0]    awvalid, wvalid, wlast, bready;
    logic [IW-1:0] awid   [2];
    logic [AW-1:0] awaddr [2];
    logic [7:0]    awlen  [2];
    logic [DW-1:0] wdata  [2];
    logic [3:0]    wstrb  [2];

    logic s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
    logic [IW-1:0] s0_bid, s1_bid;
    logic [1:0]    s0_bresp, s1_bresp;

    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic          m_bvalid, m_bready, proto_err;
    logic [IW:0]   m_awid, m_bid;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp;

    wire [1:0] awready_w = {s1_awready, s0_awready};
    wire [1:0] wready_w  = {s1_wready,  s0_wready};

    ofs_plat_axi_mem_wr_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .s0_awvalid(awvalid[0]), .s0_awready(s0_awready), .s0_awid(awid[0]),
        .s0_awaddr(awaddr[0]), .s0_awlen(awlen[0]),
        .s0_wvalid(wvalid[0]), .s0_wready(s0_wready), .s0_wdata(wdata[0]),
        .s0_wstrb(wstrb[0]), .s0_wlast(wlast[0]),
        .s0_bvalid(s0_bvalid), .s0_bready(bready[0]), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
        .s1_awvalid(awvalid[1]), .s1_awready(s1_awready), .s1_awid(awid[1]),
        .s1_awaddr(awaddr[1]), .s1_awlen(awlen[1]),
        .s1_wvalid(wvalid[1]), .s1_wready(s1_wready), .s1_wdata(wdata[1]),
        .s1_wstrb(wstrb[1]), .s1_wlast(wlast[1]),
        .s1_bvalid(s1_bvalid), .s1_bready(bready[1]), .s1_bid(s1_bid), .s1_bresp(s1_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wlast_cyc = -100;
    int aw_gap = 0;

    logic [63:0] exp_aw [$];
    logic [63:0] exp_w  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_aw(input logic src, input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len);
        exp_aw.push_back(64'({src, id, addr, len}));
    endtask

    // Pushes nb beats of data d0, d0+1, ... with wlast on the final one.
    task automatic push_w(input int src, input logic [31:0] d0, input int nb);
        logic [3:0] strb;
        strb = (src == 0) ? 4'hF : 4'h5;
        for (int i = 0; i < nb; i++)
            exp_w.push_back(64'({d0 + 32'(i), strb, (i == nb - 1)}));
    endtask

    // Drives one burst from source s; entered and left on a falling edge.
    task automatic drive(input int s, input logic [7:0] id, input logic [15:0] addr,
                         input logic [7:0] len, input int nb, input logic [31:0] d0);
        logic r;
        int n;
        awvalid[s] = 1'b1;
        awid[s]    = id;
        awaddr[s]  = addr;
        awlen[s]   = len;
        for (int i = 0; i < nb; i++) begin
            wvalid[s] = 1'b1;
            wdata[s]  = d0 + 32'(i);
            wlast[s]  = (i == nb - 1);
            n = 0;
            do begin
                #1;
                r = (i == 0) ? awready_w[s] : wready_w[s];
                @(posedge clk);
                @(negedge clk);
                n++;
            end while (!r && n < TMO);
            if (!r) begin
                total++;
                bad++;
                $display("FAIL drv_timeout src%0d beat%0d: ready=0 required=1", s, i);
            end
            if (i == 0) awvalid[s] = 1'b0;
        end
        wvalid[s] = 1'b0;
        wlast[s]  = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare each sink handshake against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (m_awvalid && m_awready && m_wready) begin
                if (exp_aw.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL aw_unexpected: got id=%0h addr=%0h", m_awid, m_awaddr);
                end else begin
                    check("aw", 64'({m_awid, m_awaddr, m_awlen}), exp_aw.pop_front());
                end
                aw_gap = cyc - last_wlast_cyc;
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL w_unexpected: got data=%0h", m_wdata);
                end else begin
                    check("w", 64'({m_wdata, m_wstrb, m_wlast}), exp_w.pop_front());
                end
                if (m_wlast) last_wlast_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
        for (int i = 0; i < 2; i++) begin
            awid[i] = '0; awaddr[i] = '0; awlen[i] = '0; wdata[i] = '0;
        end
        wstrb[0] = 4'hF;
        wstrb[1] = 4'h5;
        m_awready = 1'b1; m_wready = 1'b1;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;

        // Reset: requests and responses are all suppressed.
        repeat (2) @(negedge clk);
        awvalid = 2'b11; wvalid = 2'b11; m_bvalid = 1'b1; m_bid = 9'h100;
        #1;
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_wvalid", m_wvalid, 0);
        check("rst_awready", awready_w, 0);
        check("rst_wready", wready_w, 0);
        check("rst_bvalid", {s1_bvalid, s0_bvalid}, 0);
        check("rst_proto_err", proto_err, 0);
        @(negedge clk);
        awvalid = '0; wvalid = '0; m_bvalid = 1'b0; m_bid = '0;
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous awlen=3 bursts: s0 first, s1 immediately after.
        push_aw(1'b0, 8'h11, 16'h1000, 8'd3); push_w(0, 32'hA0, 4);
        push_aw(1'b1, 8'h22, 16'h2000, 8'd3); push_w(1, 32'hB0, 4);
        fork
            drive(0, 8'h11, 16'h1000, 8'd3, 4, 32'hA0);
            drive(1, 8'h22, 16'h2000, 8'd3, 4, 32'hB0);
        join
        #1;
        check("rr_gap_s1", 64'(aw_gap), 1);
        check("proto_err_clean", proto_err, 0);
        @(negedge clk);

        // Back-to-back single-beat bursts from different sources.
        push_aw(1'b0, 8'h33, 16'h3000, 8'd0); push_w(0, 32'hC0, 1);
        push_aw(1'b1, 8'h44, 16'h4000, 8'd0); push_w(1, 32'hD0, 1);
        fork
            drive(0, 8'h33, 16'h3000, 8'd0, 1, 32'hC0);
            drive(1, 8'h44, 16'h4000, 8'd0, 1, 32'hD0);
        join
        check("b2b_gap", 64'(aw_gap), 1);

        // AW without W is never granted.
        awvalid[0] = 1'b1; awid[0] = 8'h99; awaddr[0] = 16'h9000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("aw_only_m_awvalid", m_awvalid, 0);
            check("aw_only_awready", s0_awready, 0);
            @(negedge clk);
        end
        awvalid[0] = 1'b0;
        @(negedge clk);

        // s1 awlen=7 burst in progress; s0 arrives mid-burst and waits.
        push_aw(1'b1, 8'h55, 16'h5000, 8'd7); push_w(1, 32'hE0, 8);
        push_aw(1'b0, 8'h66, 16'h6000, 8'd1); push_w(0, 32'hF0, 2);
        fork
            drive(1, 8'h55, 16'h5000, 8'd7, 8, 32'hE0);
            begin
                repeat (2) @(negedge clk);
                drive(0, 8'h66, 16'h6000, 8'd1, 2, 32'hF0);
            end
        join
        check("holdoff_gap", 64'(aw_gap), 1);
        @(negedge clk);

        // AW ready without W ready: nothing transfers until both are high.
        m_wready = 1'b0;
        push_aw(1'b0, 8'h77, 16'h7000, 8'd0); push_w(0, 32'h70, 1);
        fork
            drive(0, 8'h77, 16'h7000, 8'd0, 1, 32'h70);
            begin
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("wstall_m_awvalid", m_awvalid, 1);
                    check("wstall_awready", s0_awready, 0);
                    @(negedge clk);
                end
                m_wready = 1'b1;
            end
        join
        check("wstall_aw_q_drained", 64'(exp_aw.size()), 0);

        // Early wlast on beat 2 of an awlen=3 burst sets a sticky error.
        #1;
        check("pre_err", proto_err, 0);
        push_aw(1'b0, 8'h88, 16'h8000, 8'd3); push_w(0, 32'h80, 2);
        drive(0, 8'h88, 16'h8000, 8'd3, 2, 32'h80);
        #1;
        check("err_set", proto_err, 1);
        @(negedge clk);
        push_aw(1'b1, 8'h12, 16'h1200, 8'd0); push_w(1, 32'h12, 1);
        drive(1, 8'h12, 16'h1200, 8'd0, 1, 32'h12);
        #1;
        check("err_sticky", proto_err, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("err_cleared_by_reset", proto_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Response routing by the top ID bit.
        m_bvalid = 1'b1; m_bid = 9'h12A; m_bresp = 2'b10; bready = 2'b10;
        #1;
        check("b1_s1_bvalid", s1_bvalid, 1);
        check("b1_s1_bid", s1_bid, 8'h2A);
        check("b1_s1_bresp", s1_bresp, 2'b10);
        check("b1_s0_bvalid", s0_bvalid, 0);
        check("b1_m_bready", m_bready, 1);
        @(negedge clk);
        bready = 2'b01;
        #1;
        check("b1_m_bready_low", m_bready, 0);
        @(negedge clk);
        m_bid = 9'h055; m_bresp = 2'b01;
        #1;
        check("b0_s0_bvalid", s0_bvalid, 1);
        check("b0_s1_bvalid", s1_bvalid, 0);
        check("b0_s0_bid", s0_bid, 8'h55);
        check("b0_m_bready", m_bready, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        repeat (2) @(negedge clk);

        check("aw_q_empty", 64'(exp_aw.size()), 0);
        check("w_q_empty", 64'(exp_w.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofs_plat_axi_mem_wr_arb2.md
OFS_PLAT_AXI_MEM_WR_ARB2 -- requirements
Module: ofs_plat_axi_mem_wr_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning AW address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning W data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 8, meaning source-side AW/B ID width; sink-side ID width is ID_WIDTH+1.
REQ-004 SHALL have ports clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-005 SHALL have, for each source s in {0,1}: s<s>_awvalid in 1; s<s>_awready out 1; s<s>_awid in ID_WIDTH; s<s>_awaddr in ADDR_WIDTH; s<s>_awlen in 8.
REQ-006 SHALL have, for each source s: s<s>_wvalid in 1; s<s>_wready out 1; s<s>_wdata in DATA_WIDTH; s<s>_wstrb in DATA_WIDTH/8; s<s>_wlast in 1.
REQ-007 SHALL have, for each source s: s<s>_bvalid out 1; s<s>_bready in 1; s<s>_bid out ID_WIDTH; s<s>_bresp out 2.
REQ-008 SHALL have sink ports m_awvalid out 1; m_awready in 1; m_awid out ID_WIDTH+1; m_awaddr out ADDR_WIDTH; m_awlen out 8.
REQ-009 SHALL have sink ports m_wvalid out 1; m_wready in 1; m_wdata out DATA_WIDTH; m_wstrb out DATA_WIDTH/8; m_wlast out 1.
REQ-010 SHALL have sink ports m_bvalid in 1; m_bready out 1; m_bid in ID_WIDTH+1; m_bresp in 2.
REQ-011 SHALL have port proto_err out 1, sticky flag for W beat count not matching awlen+1.

Function
REQ-012 SHALL implement FSM states IDLE and BURST, plus registers owner (1b), rr_last (1b), beats_left (8b), proto_err.
REQ-013 In IDLE, source s SHALL be eligible only when s<s>_awvalid && s<s>_wvalid (AW and SOP beat present together).
REQ-014 In IDLE, with both eligible, the source not equal to rr_last SHALL win; with one eligible, it SHALL win.
REQ-015 In IDLE, winner's AW and first W SHALL be presented on sink in the same cycle: m_awvalid = m_wvalid = 1.
REQ-016 Winner's awready and wready SHALL both equal m_awready && m_wready; the AW+SOP transfer completes only when both are high in the same cycle.
REQ-017 Until the AW+SOP transfer completes, the grant SHALL be recomputed each cycle; no state SHALL change.
REQ-018 On AW+SOP transfer: rr_last <= winner; owner <= winner; beats_left <= awlen.
REQ-019 On that transfer, if wlast=0 the FSM SHALL go to BURST; if wlast=1 it SHALL stay in IDLE.
REQ-020 In BURST, only owner's W SHALL be forwarded (m_wvalid = owner wvalid, owner wready = m_wready); m_awvalid = 0; the other source's awready/wready = 0.
REQ-021 In BURST, each accepted beat SHALL decrement beats_left; the beat with wlast=1 SHALL return FSM to IDLE the next cycle.
REQ-022 proto_err SHALL set when an accepted beat has wlast=1 with beats_left != 0, or wlast=0 with beats_left == 0; it SHALL clear only on reset.
REQ-023 m_awid SHALL equal {winner, s<winner>_awid}; m_aw*/m_w* payloads SHALL be muxed from the selected source.
REQ-024 B SHALL route by m_bid[ID_WIDTH]: s<m_bid[ID_WIDTH]>_bvalid = m_bvalid; m_bready = that source's bready; bid = m_bid[ID_WIDTH-1:0]; the other source's bvalid = 0.
REQ-025 Arbiter SHALL add zero cycles of latency; all payload paths SHALL be combinational.
REQ-026 Two back-to-back single-beat bursts from different sources SHALL be able to issue on consecutive cycles.

Reset
REQ-027 While reset is high: state = IDLE, rr_last = 1 (source 0 wins first tie), owner = 0, beats_left = 0, proto_err = 0.
REQ-028 While reset is high, all source ready outputs, m_awvalid, m_wvalid, and all s<s>_bvalid SHALL be 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst and return to IDLE; no recovery of the partial burst is required.

Verification
REQ-030 Both sources present awlen=3 bursts at once, sink always ready -> s0's AW+4 beats, then s1's AW+4 beats; m_awid[ID_WIDTH] = 0 then 1; proto_err = 0.
REQ-031 s0 presents awvalid without wvalid for 5 cycles, s1 idle -> m_awvalid = 0 and s0_awready = 0 throughout.
REQ-032 s1 burst awlen=7 in progress, s0 requests at beat 2 -> s0 is held off until the cycle after s1's wlast beat, then granted.
REQ-033 m_awready=1 with m_wready=0 for 3 cycles at grant -> no AW transfer is counted; AW and W complete together on the first cycle both are ready.
REQ-034 Source sends wlast on beat 2 of an awlen=3 burst -> proto_err = 1 the following cycle and stays 1 until reset.
REQ-035 m_bvalid with m_bid = {1'b1, 8'h2A} -> s1_bvalid = 1, s1_bid = 8'h2A, s0_bvalid = 0; m_bready follows s1_bready.
